// File: rtl/exe_stage_reduced.sv
// Reduced execute stage: combinational ADD/SUB/JAL/JALR path plus a multi-cycle MUL / signed DIV unit.
// Arith path 0 cycles; MUL result 2 edges after accept, DIV after DIV_CYCLES busy cycles; stall_o holds upstream while busy.
module exe_stage_reduced #(
    parameter int DATA_W     = 64,
    parameter int DIV_CYCLES = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              kill_i,
    input  logic              valid_i,
    input  logic [2:0]        op_i,
    input  logic              use_imm_i,
    input  logic [DATA_W-1:0] pc_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic [DATA_W-1:0] rs1_i,
    input  logic [DATA_W-1:0] rs2_i,
    output logic              arith_valid_o,
    output logic [DATA_W-1:0] arith_result_o,
    output logic [DATA_W-1:0] arith_result_pc_o,
    output logic              muldiv_valid_o,
    output logic [DATA_W-1:0] muldiv_result_o,
    output logic              stall_o,
    output logic              struct_stall_o
);
    localparam int CNT_W = $clog2(DIV_CYCLES + 1);

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_MUL  = 3'd2;
    localparam logic [2:0] OP_DIV  = 3'd3;
    localparam logic [2:0] OP_JAL  = 3'd4;
    localparam logic [2:0] OP_JALR = 3'd5;

    typedef enum logic [1:0] {S_IDLE, S_MUL_BUSY, S_DIV_BUSY, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  opa_q, opa_d;     // MUL rs1, or DIV dividend magnitude / quotient shift register
    logic [DATA_W-1:0]  opb_q, opb_d;     // MUL rs2, or DIV divisor magnitude
    logic [DATA_W-1:0]  rem_q, rem_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic               dz_q, dz_d;
    logic [DATA_W-1:0]  res_q, res_d;

    // ---------------- combinational arith/branch path ----------------
    logic [DATA_W-1:0] op2;
    logic [DATA_W-1:0] jalr_sum;

    always_comb begin
        op2               = use_imm_i ? imm_i : rs2_i;
        jalr_sum          = rs1_i + imm_i;
        arith_result_o    = '0;
        arith_result_pc_o = '0;
        arith_valid_o     = 1'b0;
        case (op_i)
            OP_ADD:  begin arith_result_o = rs1_i + op2; arith_valid_o = valid_i && !kill_i; end
            OP_SUB:  begin arith_result_o = rs1_i - op2; arith_valid_o = valid_i && !kill_i; end
            OP_JAL:  begin arith_result_o = pc_i + DATA_W'(4); arith_valid_o = valid_i && !kill_i; end
            OP_JALR: begin
                arith_result_o    = pc_i + DATA_W'(4);
                arith_result_pc_o = {jalr_sum[DATA_W-1:1], 1'b0};
                arith_valid_o     = valid_i && !kill_i;
            end
            default: ;
        endcase
    end

    // ---------------- multi-cycle MUL/DIV ----------------
    logic              accept;
    logic [DATA_W-1:0] rs1_mag, rs2_mag;
    logic [DATA_W-1:0] prod;
    logic              rem_hi;
    logic [DATA_W-1:0] rem_lo;
    logic              ge;
    logic [DATA_W-1:0] rem_nxt, quot_nxt, quot_fix;

    assign stall_o        = (state_q == S_MUL_BUSY) || (state_q == S_DIV_BUSY);
    assign struct_stall_o = valid_i && stall_o;
    assign muldiv_valid_o = (state_q == S_DONE);
    assign muldiv_result_o = res_q;

    always_comb begin
        accept  = valid_i && !kill_i && !stall_o && ((op_i == OP_MUL) || (op_i == OP_DIV));
        rs1_mag = rs1_i[DATA_W-1] ? -rs1_i : rs1_i;
        rs2_mag = rs2_i[DATA_W-1] ? -rs2_i : rs2_i;
        prod    = opa_q * opb_q;

        // One restoring step: the shifted-out remainder bit means the partial remainder already exceeds the divisor.
        rem_hi   = rem_q[DATA_W-1];
        rem_lo   = {rem_q[DATA_W-2:0], opa_q[DATA_W-1]};
        ge       = rem_hi || (rem_lo >= opb_q);
        rem_nxt  = ge ? (rem_lo - opb_q) : rem_lo;
        quot_nxt = {opa_q[DATA_W-2:0], ge};
        quot_fix = dz_q ? '1 : (neg_q ? -quot_nxt : quot_nxt);

        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        dz_d    = dz_q;
        res_d   = res_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept && (op_i == OP_MUL)) begin
                    state_d = S_MUL_BUSY;
                    opa_d   = rs1_i;
                    opb_d   = rs2_i;
                end else if (accept) begin
                    state_d = S_DIV_BUSY;
                    opa_d   = rs1_mag;
                    opb_d   = rs2_mag;
                    rem_d   = '0;
                    cnt_d   = '0;
                    neg_d   = rs1_i[DATA_W-1] ^ rs2_i[DATA_W-1];
                    dz_d    = (rs2_i == '0);
                end
            end
            S_MUL_BUSY: begin
                state_d = S_DONE;
                res_d   = prod;
            end
            S_DIV_BUSY: begin
                opa_d = quot_nxt;
                rem_d = rem_nxt;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DIV_CYCLES - 1)) begin
                    state_d = S_DONE;
                    res_d   = quot_fix;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (kill_i) begin
            state_d = S_IDLE;
            res_d   = res_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            dz_q    <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            dz_q    <= dz_d;
            res_q   <= res_d;
        end
    end
endmodule

// File: tb/tb_exe_stage_reduced.sv
// Randomized self-checking bench for exe_stage_reduced against a behavioural reference model.
module tb_exe_stage_reduced;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        kill_i;
    logic        valid_i;
    logic [2:0]  op_i;
    logic        use_imm_i;
    logic [63:0] pc_i, imm_i, rs1_i, rs2_i;
    logic        arith_valid_o;
    logic [63:0] arith_result_o, arith_result_pc_o;
    logic        muldiv_valid_o;
    logic [63:0] muldiv_result_o;
    logic        stall_o, struct_stall_o;

    int checks = 0;
    int errors = 0;

    exe_stage_reduced #(.DATA_W(64), .DIV_CYCLES(64)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .kill_i(kill_i), .valid_i(valid_i), .op_i(op_i),
        .use_imm_i(use_imm_i), .pc_i(pc_i), .imm_i(imm_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
        .arith_valid_o(arith_valid_o), .arith_result_o(arith_result_o),
        .arith_result_pc_o(arith_result_pc_o), .muldiv_valid_o(muldiv_valid_o),
        .muldiv_result_o(muldiv_result_o), .stall_o(stall_o), .struct_stall_o(struct_stall_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #3000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [63:0] ref_div(input logic [63:0] a, input logic [63:0] b);
        longint sa, sb;
        if (b == 64'd0) return 64'hFFFF_FFFF_FFFF_FFFF;
        if (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) return a;
        sa = a;
        sb = b;
        return 64'(sa / sb);
    endfunction

    task automatic arith_chk(input string tag, input logic [2:0] op, input logic [63:0] a,
                             input logic [63:0] b, input logic [63:0] imm, input logic [63:0] pc,
                             input logic ui, input logic kill);
        logic [63:0] o2, er, ep;
        logic        ev;
        @(negedge clk_i);
        valid_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b; imm_i = imm; pc_i = pc;
        use_imm_i = ui; kill_i = kill;
        #1;
        o2 = ui ? imm : b;
        er = 64'd0;
        ep = 64'd0;
        ev = 1'b0;
        case (op)
            3'd0: begin er = a + o2; ev = 1'b1; end
            3'd1: begin er = a - o2; ev = 1'b1; end
            3'd4: begin er = pc + 64'd4; ev = 1'b1; end
            3'd5: begin er = pc + 64'd4; ep = (a + imm) & ~64'd1; ev = 1'b1; end
            default: ;
        endcase
        if (kill) ev = 1'b0;
        check_eq({tag, "_res"}, arith_result_o, er);
        check_eq({tag, "_pc"}, arith_result_pc_o, ep);
        check_eq({tag, "_vld"}, arith_valid_o, ev);
        valid_i = 1'b0;
        kill_i = 1'b0;
    endtask

    // Presents a MUL/DIV in the current cycle; the unit must be ready to take it.
    task automatic issue(input string tag, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        valid_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b; use_imm_i = 1'b0; kill_i = 1'b0;
        #1;
        check_eq({tag, "_rdy"}, stall_o, 1'b0);
    endtask

    // Counts busy cycles after an accept and checks the completion pulse and result.
    task automatic finish_md(input string tag, input int lat, input logic [63:0] exp);
        int n;
        n = 0;
        @(negedge clk_i);
        valid_i = 1'b0;
        while (stall_o === 1'b1 && n < 300) begin
            if (muldiv_valid_o !== 1'b0) check_eq({tag, "_early"}, muldiv_valid_o, 1'b0);
            @(negedge clk_i);
            n++;
        end
        check_eq({tag, "_lat"}, 64'(n), 64'(lat));
        check_eq({tag, "_vld"}, muldiv_valid_o, 1'b1);
        check_eq({tag, "_res"}, muldiv_result_o, exp);
    endtask

    task automatic run_md(input string tag, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] exp;
        exp = (op == 3'd2) ? a * b : ref_div(a, b);
        @(negedge clk_i);
        issue(tag, op, a, b);
        finish_md(tag, (op == 3'd2) ? 1 : 64, exp);
        @(negedge clk_i);
        check_eq({tag, "_pulse1"}, muldiv_valid_o, 1'b0);
        check_eq({tag, "_hold"}, muldiv_result_o, exp);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [63:0] a, b, prev;
        int          pulses;

        rst_i = 1'b1; kill_i = 1'b0; valid_i = 1'b0; op_i = 3'd0; use_imm_i = 1'b0;
        pc_i = 64'd0; imm_i = 64'd0; rs1_i = 64'd0; rs2_i = 64'd0;
        #1;
        check_eq("rst_stall", stall_o, 1'b0);
        check_eq("rst_vld", muldiv_valid_o, 1'b0);
        check_eq("rst_res", muldiv_result_o, 64'd0);
        check_eq("rst_sstall", struct_stall_o, 1'b0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;

        // directed arith / branch
        arith_chk("add_wrap", 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd0, 64'd0, 1'b0, 1'b0);
        arith_chk("sub_neg", 3'd1, 64'd5, 64'd7, 64'd0, 64'd0, 1'b0, 1'b0);
        arith_chk("jal", 3'd4, 64'h2000, 64'd0, 64'h21, 64'h1000, 1'b0, 1'b0);
        arith_chk("jalr", 3'd5, 64'h2000, 64'd0, 64'h21, 64'h1000, 1'b0, 1'b0);
        arith_chk("add_imm", 3'd0, 64'd10, 64'd99, 64'hFFFF_FFFF_FFFF_FFFD, 64'd0, 1'b1, 1'b0);
        arith_chk("add_kill", 3'd0, 64'd1, 64'd2, 64'd0, 64'd0, 1'b0, 1'b1);
        arith_chk("rsvd6", 3'd6, 64'd1, 64'd2, 64'd3, 64'd4, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) arith_chk("add_rnd", 3'd0, rnd64(), rnd64(), rnd64(), rnd64(), 1'($urandom), 1'b0);
        for (int i = 0; i < 100; i++) arith_chk("sub_rnd", 3'd1, rnd64(), rnd64(), rnd64(), rnd64(), 1'($urandom), 1'b0);
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0: rop = 3'd4;
                1: rop = 3'd5;
                2: rop = 3'd7;
                default: rop = 3'd6;
            endcase
            arith_chk("br_rnd", rop, rnd64(), rnd64(), rnd64(), rnd64(), 1'($urandom), 1'($urandom_range(0, 7) == 0));
        end

        // MUL
        run_md("mul_dir", 3'd2, 64'h1_0000_0000, 64'h1_0000_0003);
        for (int i = 0; i < 100; i++) run_md("mul_rnd", 3'd2, rnd64(), rnd64());

        // DIV
        run_md("div_dir", 3'd3, -64'd100, 64'd7);
        run_md("div_zero", 3'd3, 64'd12345, 64'd0);
        run_md("div_zero_neg", 3'd3, -64'd9, 64'd0);
        run_md("div_ovf", 3'd3, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
        run_md("div_exact", 3'd3, -64'd42, -64'd6);
        for (int i = 0; i < 20; i++) begin
            a = rnd64();
            b = ($urandom_range(0, 1) != 0) ? 64'($urandom_range(1, 1000)) : rnd64();
            if ($urandom_range(0, 1) != 0) b = -b;
            run_md("div_rnd", 3'd3, a, b);
        end

        // kill mid-DIV, with an ADD presented during the stall
        prev = muldiv_result_o;
        @(negedge clk_i);
        issue("kill_div", 3'd3, 64'd1000, 64'd3);
        @(negedge clk_i);
        valid_i = 1'b0;
        repeat (4) @(negedge clk_i);
        valid_i = 1'b1; op_i = 3'd0; rs1_i = 64'd3; rs2_i = 64'd4; use_imm_i = 1'b0;
        #1;
        check_eq("stall_add_res", arith_result_o, 64'd7);
        check_eq("stall_add_vld", arith_valid_o, 1'b1);
        check_eq("stall_sstall", struct_stall_o, 1'b1);
        valid_i = 1'b0;
        repeat (5) @(negedge clk_i);
        check_eq("kill_busy", stall_o, 1'b1);
        kill_i = 1'b1;
        @(negedge clk_i);
        kill_i = 1'b0;
        check_eq("kill_stall", stall_o, 1'b0);
        pulses = 0;
        repeat (70) begin
            if (muldiv_valid_o === 1'b1) pulses++;
            @(negedge clk_i);
        end
        check_eq("kill_nopulse", 64'(pulses), 64'd0);
        check_eq("kill_hold", muldiv_result_o, prev);

        // instruction presented with kill is dropped
        valid_i = 1'b1; op_i = 3'd2; rs1_i = 64'd6; rs2_i = 64'd7; kill_i = 1'b1;
        @(negedge clk_i);
        valid_i = 1'b0; kill_i = 1'b0;
        check_eq("killacc_stall", stall_o, 1'b0);
        @(negedge clk_i);
        check_eq("killacc_vld", muldiv_valid_o, 1'b0);
        check_eq("killacc_res", muldiv_result_o, prev);

        // back-to-back: MUL accepted in DIV completion cycle
        @(negedge clk_i);
        issue("b2b_div", 3'd3, 64'd77, 64'd7);
        finish_md("b2b_div", 64, 64'd11);
        issue("b2b_mul", 3'd2, 64'd9, 64'd8);
        finish_md("b2b_mul", 1, 64'd72);
        @(negedge clk_i);
        check_eq("b2b_end", muldiv_valid_o, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
